// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the buffered 1-to-2 demultiplexer.
//   CH0 / CH1        : sel encodings for output channel 0 and channel 1.
//   DEFAULT_WIDTH    : default data width.
//   DEFAULT_DEPTH    : default per-channel FIFO depth (power of two, >= 2).
//   count_w()        : width of an occupancy counter that must hold 0..depth.
package demux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;

  // One extra bit over the pointer width so the value DEPTH itself fits.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: single-clock synchronous FIFO used as one output channel of
// demux1to2_buf.
// Ports:
//   clk     : clock, all state changes on the rising edge.
//   rst_n   : synchronous active-low reset; empties the FIFO and overrides
//             any push/pop in the same cycle.
//   push    : write wdata this edge (ignored while full).
//   wdata   : data to write.
//   pop     : advance the head this edge (ignored while empty).
//   rdata   : head entry; forced to 0 while empty.
//   full    : count == DEPTH (registered state only).
//   empty   : count == 0 (registered state only).
//   count   : occupancy, 0..DEPTH.
// Handshake: the owner presents push/pop as already-qualified transfer
// strobes; a word written at edge N is visible on rdata after edge N, never
// in the same cycle it is written (no fall-through).
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  logic do_push;
  logic do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // A push into a full FIFO or a pop from an empty one is dropped here as a
  // second line of defence; the top already qualifies push with in_ready.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage itself is not reset; rdata is masked while empty so the
  // post-reset head reads as zero.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && rst_n) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/demux1to2_buf.sv
// demux1to2_buf: buffered 1-to-2 demultiplexer. Each input word is steered by
// sel into one of two independent output FIFOs, so a stalled consumer on one
// channel only blocks input words that target that channel.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset.
//   in_valid/in_ready   : input handshake; in_data and sel travel with it.
//   in_data [WIDTH]     : input word.
//   sel                 : destination (CH0 -> y0, CH1 -> y1).
//   y0_valid/y0_ready   : channel 0 output handshake.
//   y0_data [WIDTH]     : channel 0 head entry.
//   y0_count            : channel 0 occupancy, 0..DEPTH.
//   y1_*                : same for channel 1.
// Handshake (all interfaces): a transfer happens at a rising edge where
// valid and ready are both 1. A producer holding valid=1 with ready=0 must
// keep its data (and sel) stable. in_ready depends only on rst_n, sel and
// registered full flags, never on y*_ready, so a full channel refuses a push
// even in a cycle where it is being popped; the word goes in next cycle.
// A word blocked on a full channel is never redirected or dropped.
module demux1to2_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      sel,
  output logic                      y0_valid,
  input  logic                      y0_ready,
  output logic [WIDTH-1:0]          y0_data,
  output logic [count_w(DEPTH)-1:0] y0_count,
  output logic                      y1_valid,
  input  logic                      y1_ready,
  output logic [WIDTH-1:0]          y1_data,
  output logic [count_w(DEPTH)-1:0] y1_count
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic accept;

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = (sel == CH1) ? ~full1 : ~full0;
    end
  end

  assign accept = in_valid & in_ready;
  assign push0  = accept & (sel == CH0);
  assign push1  = accept & (sel == CH1);

  assign y0_valid = ~empty0;
  assign y1_valid = ~empty1;

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .wdata (in_data),
    .pop   (y0_ready),
    .rdata (y0_data),
    .full  (full0),
    .empty (empty0),
    .count (y0_count)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .wdata (in_data),
    .pop   (y1_ready),
    .rdata (y1_data),
    .full  (full1),
    .empty (empty1),
    .count (y1_count)
  );

endmodule

// File: tb/tb_demux1to2_buf.sv
module tb_demux1to2_buf;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          sel;
  logic          y0_valid, y1_valid;
  logic          y0_ready, y1_ready;
  logic [W-1:0]  y0_data, y1_data;
  logic [CW-1:0] y0_count, y1_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  demux1to2_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y0_data  (y0_data),
    .y0_count (y0_count),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .y1_data  (y1_data),
    .y1_count (y1_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: at the falling edge every signal for the coming rising edge
  // is stable, so transfers seen here are exactly what the next edge does.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      exp0_q.delete();
      exp1_q.delete();
    end else begin
      if (y0_valid && y0_ready) begin
        chk_cnt++;
        if (exp0_q.size() == 0) begin
          $display("FAIL sb_y0: got %h, expected queue empty", y0_data);
        end else begin
          e = exp0_q.pop_front();
          if (y0_data !== e) $display("FAIL sb_y0: got %h, expected %h", y0_data, e);
          else pass_cnt++;
        end
      end
      if (y1_valid && y1_ready) begin
        chk_cnt++;
        if (exp1_q.size() == 0) begin
          $display("FAIL sb_y1: got %h, expected queue empty", y1_data);
        end else begin
          e = exp1_q.pop_front();
          if (y1_data !== e) $display("FAIL sb_y1: got %h, expected %h", y1_data, e);
          else pass_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        if (sel) exp1_q.push_back(in_data);
        else     exp0_q.push_back(in_data);
      end
    end
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [W-1:0] d);
    in_valid = 1'b1;
    sel      = s;
    in_data  = d;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
    sel      = $urandom_range(0, 1);
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, expected 1", in_ready); else pass_cnt++;
    chk_cnt++; if (y0_valid !== 1'b0) $display("FAIL rst_y0_valid: got %b, expected 0", y0_valid); else pass_cnt++;
    chk_cnt++; if (y1_valid !== 1'b0) $display("FAIL rst_y1_valid: got %b, expected 0", y1_valid); else pass_cnt++;
    chk_cnt++; if (y0_count !== '0) $display("FAIL rst_y0_count: got %0d, expected 0", y0_count); else pass_cnt++;
    chk_cnt++; if (y1_count !== '0) $display("FAIL rst_y1_count: got %0d, expected 0", y1_count); else pass_cnt++;
    chk_cnt++; if (y0_data !== '0) $display("FAIL rst_y0_data: got %h, expected 00", y0_data); else pass_cnt++;
    chk_cnt++; if (y1_data !== '0) $display("FAIL rst_y1_data: got %h, expected 00", y1_data); else pass_cnt++;
  endtask

  task automatic test_alternating();
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    drive(1'b0, 8'hA1);
    tick();
    chk_cnt++; if (y0_valid !== 1'b1 || y0_data !== 8'hA1) $display("FAIL alt_a1: got v=%b d=%h, expected v=1 d=a1", y0_valid, y0_data); else pass_cnt++;
    drive(1'b1, 8'hB2);
    tick();
    chk_cnt++; if (y1_valid !== 1'b1 || y1_data !== 8'hB2) $display("FAIL alt_b2: got v=%b d=%h, expected v=1 d=b2", y1_valid, y1_data); else pass_cnt++;
    chk_cnt++; if (y0_valid !== 1'b0) $display("FAIL alt_y0_drained: got %b, expected 0", y0_valid); else pass_cnt++;
    drive(1'b0, 8'hA3);
    tick();
    chk_cnt++; if (y0_valid !== 1'b1 || y0_data !== 8'hA3) $display("FAIL alt_a3: got v=%b d=%h, expected v=1 d=a3", y0_valid, y0_data); else pass_cnt++;
    idle_in();
    tick();
    chk_cnt++; if (y0_count !== '0 || y1_count !== '0) $display("FAIL alt_empty: got c0=%0d c1=%0d, expected 0 0", y0_count, y1_count); else pass_cnt++;
  endtask

  task automatic test_fill_ch0();
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    drive(1'b0, 8'h11);
    tick();
    drive(1'b0, 8'h22);
    tick();
    drive(1'b0, 8'h33);
    #1;
    chk_cnt++; if (y0_count !== CW'(2)) $display("FAIL fill_count: got %0d, expected 2", y0_count); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b, expected 0", in_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (y0_count !== CW'(2) || y0_data !== 8'h11) $display("FAIL fill_hold: got c=%0d d=%h, expected c=2 d=11", y0_count, y0_data); else pass_cnt++;
    // pop while full: the push is refused this edge
    y0_ready = 1'b1;
    tick();
    chk_cnt++; if (y0_count !== CW'(1) || y0_data !== 8'h22) $display("FAIL fill_pop: got c=%0d d=%h, expected c=1 d=22", y0_count, y0_data); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL fill_reopen: got %b, expected 1", in_ready); else pass_cnt++;
    y0_ready = 1'b0;
    tick();
    idle_in();
    chk_cnt++; if (y0_count !== CW'(2)) $display("FAIL fill_accept33: got %0d, expected 2", y0_count); else pass_cnt++;
  endtask

  task automatic test_other_channel();
    drive(1'b1, 8'h55);
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL other_in_ready: got %b, expected 1", in_ready); else pass_cnt++;
    tick();
    idle_in();
    chk_cnt++; if (y1_valid !== 1'b1 || y1_data !== 8'h55) $display("FAIL other_y1: got v=%b d=%h, expected v=1 d=55", y1_valid, y1_data); else pass_cnt++;
    chk_cnt++; if (y0_count !== CW'(2)) $display("FAIL other_y0_count: got %0d, expected 2", y0_count); else pass_cnt++;
    // drain: y0 yields 22, 33; y1 yields 55 (checked by scoreboard)
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk_cnt++; if (y0_count !== '0 || y1_count !== '0) $display("FAIL other_drain: got c0=%0d c1=%0d, expected 0 0", y0_count, y1_count); else pass_cnt++;
  endtask

  task automatic test_push_pop_same();
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    drive(1'b0, 8'h66);
    tick();
    drive(1'b0, 8'h77);
    y0_ready = 1'b1;
    tick();
    idle_in();
    chk_cnt++; if (y0_count !== CW'(1) || y0_data !== 8'h77) $display("FAIL pushpop: got c=%0d d=%h, expected c=1 d=77", y0_count, y0_data); else pass_cnt++;
    tick();
    y0_ready = 1'b0;
    chk_cnt++; if (y0_valid !== 1'b0) $display("FAIL pushpop_drain: got %b, expected 0", y0_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    drive(1'b0, 8'hC1);
    tick();
    drive(1'b1, 8'hD1);
    tick();
    idle_in();
    chk_cnt++; if (y0_count !== CW'(1) || y1_count !== CW'(1)) $display("FAIL mid_pre: got c0=%0d c1=%0d, expected 1 1", y0_count, y1_count); else pass_cnt++;
    rst_n = 1'b0;
    drive(1'b0, 8'hEE);
    y0_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    idle_in();
    y0_ready = 1'b0;
    #1;
    chk_cnt++; if (y0_count !== '0 || y1_count !== '0) $display("FAIL mid_count: got c0=%0d c1=%0d, expected 0 0", y0_count, y1_count); else pass_cnt++;
    chk_cnt++; if (y0_valid !== 1'b0 || y1_valid !== 1'b0) $display("FAIL mid_valid: got v0=%b v1=%b, expected 0 0", y0_valid, y1_valid); else pass_cnt++;
    drive(1'b0, 8'hE5);
    tick();
    idle_in();
    chk_cnt++; if (y0_valid !== 1'b1 || y0_data !== 8'hE5) $display("FAIL mid_head: got v=%b d=%h, expected v=1 d=e5", y0_valid, y0_data); else pass_cnt++;
    y0_ready = 1'b1;
    tick();
    y0_ready = 1'b0;
    tick();
  endtask

  task automatic test_random_bursts();
    int budget;
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 255));
      budget = 0;
      while (budget < 50) begin
        y0_ready = ($urandom_range(0, 3) != 0);
        y1_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (in_ready) break;
        tick();
        budget++;
      end
      if (budget >= 50) begin
        chk_cnt++;
        $display("FAIL rand_stall: in_ready stuck at %b, expected 1 within 50 cycles", in_ready);
      end
      tick();
    end
    idle_in();
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    for (int i = 0; i < 2 * D + 2; i++) tick();
  endtask

  task automatic test_drain_report();
    chk_cnt++; if (exp0_q.size() != 0) $display("FAIL final_q0: got %0d words outstanding, expected 0", exp0_q.size()); else pass_cnt++;
    chk_cnt++; if (exp1_q.size() != 0) $display("FAIL final_q1: got %0d words outstanding, expected 0", exp1_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_fill_ch0();
    test_other_channel();
    test_push_pop_same();
    test_reset_mid();
    test_random_bursts();
    test_drain_report();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
